// File: rtl/as_gpio_seq_checker.sv
// GPIO result monitor: compares each chip-select write event against a
// programmable table of expected values and holds a sticky pass/fail verdict.
//
// state | meaning
// IDLE  | out of reset, waiting for start_i
// RUN   | armed, comparing events in order against the table
// PASS  | all expected writes matched; a further write is overlength
// FAIL  | sticky failure, cause/index/data held until start_i or reset
module as_gpio_seq_checker #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int TO_W   = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cs_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              exp_we_i,
  input  logic [IDX_W-1:0]  exp_addr_i,
  input  logic [DATA_W-1:0] exp_data_i,
  input  logic [IDX_W:0]    exp_len_i,
  input  logic [TO_W-1:0]   timeout_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic [1:0]        cause_o,
  output logic [IDX_W:0]    match_cnt_o,
  output logic [IDX_W:0]    fail_idx_o,
  output logic [DATA_W-1:0] fail_data_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISMATCH = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_OVERLEN  = 2'b11;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_table [DEPTH];
  logic              r_cs_q;
  logic [IDX_W:0]    r_len;
  logic [TO_W-1:0]   r_limit;
  logic [IDX_W:0]    r_idx;
  logic [TO_W-1:0]   r_to_cnt;
  logic [1:0]        r_cause;
  logic [IDX_W:0]    r_fail_idx;
  logic [DATA_W-1:0] r_fail_data;

  logic              w_event;
  logic              w_hit;
  logic              w_expire;
  logic              w_start_ok;
  logic [IDX_W:0]    w_idx_inc;

  assign w_event    = cs_i & ~r_cs_q;
  assign w_hit      = (data_i == r_table[r_idx[IDX_W-1:0]]);
  assign w_expire   = (r_limit != '0) && (r_to_cnt == (r_limit - TO_W'(1)));
  assign w_start_ok = start_i && (r_state != S_RUN);
  assign w_idx_inc  = r_idx + (IDX_W+1)'(1);

  // The table has no reset so a program can be loaded once and re-run
  always_ff @(posedge clk_i) begin
    if (exp_we_i && (r_state != S_RUN)) begin
      r_table[exp_addr_i] <= exp_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        if (w_event) begin
          if (!w_hit) begin
            w_state_nxt = S_FAIL;
          end else if (w_idx_inc == r_len) begin
            w_state_nxt = S_PASS;
          end
        end else if (w_expire) begin
          w_state_nxt = S_FAIL;
        end
      end
      default: begin
        if (start_i) begin
          w_state_nxt = (exp_len_i == '0) ? S_PASS : S_RUN;
        end else if ((r_state == S_PASS) && w_event) begin
          w_state_nxt = S_FAIL;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cs_q      <= 1'b0;
      r_len       <= '0;
      r_limit     <= '0;
      r_idx       <= '0;
      r_to_cnt    <= '0;
      r_cause     <= CAUSE_NONE;
      r_fail_idx  <= '0;
      r_fail_data <= '0;
    end else begin
      r_cs_q <= cs_i;
      if (w_start_ok) begin
        r_len       <= exp_len_i;
        r_limit     <= timeout_i;
        r_idx       <= '0;
        r_to_cnt    <= '0;
        r_cause     <= CAUSE_NONE;
        r_fail_idx  <= '0;
        r_fail_data <= '0;
      end else if (r_state == S_RUN) begin
        if (w_event) begin
          if (w_hit) begin
            r_idx    <= w_idx_inc;
            r_to_cnt <= '0;
          end else begin
            r_cause     <= CAUSE_MISMATCH;
            r_fail_idx  <= r_idx;
            r_fail_data <= data_i;
          end
        end else if (w_expire) begin
          r_cause    <= CAUSE_TIMEOUT;
          r_fail_idx <= r_idx;
        end else if (r_to_cnt != '1) begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
        end
      end else if ((r_state == S_PASS) && w_event) begin
        r_cause     <= CAUSE_OVERLEN;
        r_fail_idx  <= r_len;
        r_fail_data <= data_i;
      end
    end
  end

  // Index and match count always move together, so one register serves both
  always_comb begin
    busy_o      = (r_state == S_RUN);
    pass_o      = (r_state == S_PASS);
    fail_o      = (r_state == S_FAIL);
    cause_o     = r_cause;
    match_cnt_o = r_idx;
    fail_idx_o  = r_fail_idx;
    fail_data_o = r_fail_data;
  end

endmodule

// File: tb/tb_as_gpio_seq_checker.sv
// Self-checking bench for as_gpio_seq_checker: a per-cycle vector table plus
// hand-written sequences for timeout, re-arm, full depth and async reset.
module tb_as_gpio_seq_checker;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 16;
  localparam int IDX_W  = 4;
  localparam int TO_W   = 24;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              cs = 1'b0;
  logic [DATA_W-1:0] data = '0;
  logic              we = 1'b0;
  logic [IDX_W-1:0]  waddr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [IDX_W:0]    len = '0;
  logic [TO_W-1:0]   tmo = '0;
  logic              start = 1'b0;
  logic              busy_o, pass_o, fail_o;
  logic [1:0]        cause_o;
  logic [IDX_W:0]    match_cnt_o, fail_idx_o;
  logic [DATA_W-1:0] fail_data_o;

  as_gpio_seq_checker #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TO_W(TO_W)) dut (
    .clk_i(clk), .rst_i(rst_n), .cs_i(cs), .data_i(data),
    .exp_we_i(we), .exp_addr_i(waddr), .exp_data_i(wdata),
    .exp_len_i(len), .timeout_i(tmo), .start_i(start),
    .busy_o(busy_o), .pass_o(pass_o), .fail_o(fail_o), .cause_o(cause_o),
    .match_cnt_o(match_cnt_o), .fail_idx_o(fail_idx_o), .fail_data_o(fail_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        busy, pass, fail;
    logic [1:0]  cause;
    logic [4:0]  mcnt, fidx;
    logic [63:0] fdata;
  } exp_t;

  typedef struct {
    logic        st;
    logic [4:0]  len;
    logic [23:0] tmo;
    logic        cs;
    logic [63:0] d;
    logic        busy, pass, fail;
    logic [1:0]  cause;
    logic [4:0]  mcnt, fidx;
    logic [63:0] fdata;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic compare_out(input exp_t e);
    chk({e.nm, ".busy"},  64'(busy_o),      64'(e.busy));
    chk({e.nm, ".pass"},  64'(pass_o),      64'(e.pass));
    chk({e.nm, ".fail"},  64'(fail_o),      64'(e.fail));
    chk({e.nm, ".cause"}, 64'(cause_o),     64'(e.cause));
    chk({e.nm, ".mcnt"},  64'(match_cnt_o), 64'(e.mcnt));
    chk({e.nm, ".fidx"},  64'(fail_idx_o),  64'(e.fidx));
    chk({e.nm, ".fdata"}, fail_data_o,      e.fdata);
  endtask

  function automatic exp_t mk_exp(input string nm, input logic b, input logic p, input logic f,
                                  input logic [1:0] c, input logic [4:0] m, input logic [4:0] fi,
                                  input logic [63:0] fd);
    exp_t e;
    e.nm = nm; e.busy = b; e.pass = p; e.fail = f;
    e.cause = c; e.mcnt = m; e.fidx = fi; e.fdata = fd;
    return e;
  endfunction

  function automatic vec_t mk_vec(input logic st, input logic [4:0] l, input logic [23:0] t,
                                  input logic c, input logic [63:0] d, input logic b,
                                  input logic p, input logic f, input logic [1:0] ca,
                                  input logic [4:0] m, input logic [4:0] fi, input logic [63:0] fd);
    vec_t v;
    v.st = st; v.len = l; v.tmo = t; v.cs = c; v.d = d;
    v.busy = b; v.pass = p; v.fail = f; v.cause = ca; v.mcnt = m; v.fidx = fi; v.fdata = fd;
    return v;
  endfunction

  // Advance one clock, then check every expectation queued for that edge
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      compare_out(e);
    end
  endtask

  task automatic expect_now(input string nm, input logic b, input logic p, input logic f,
                            input logic [1:0] c, input logic [4:0] m, input logic [4:0] fi,
                            input logic [63:0] fd);
    sb_q.push_back(mk_exp(nm, b, p, f, c, m, fi, fd));
  endtask

  task automatic load(input int a, input logic [63:0] d);
    we = 1'b1; waddr = IDX_W'(a); wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic arm(input string nm, input logic [4:0] l, input logic [23:0] t);
    start = 1'b1; len = l; tmo = t;
    expect_now(nm, (l != 0), (l == 0), 1'b0, 2'b00, 5'd0, 5'd0, 64'd0);
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Async reset with no clock edge: outputs must clear immediately
    #1 rst_n = 1'b0;
    #1;
    compare_out(mk_exp("reset", 0, 0, 0, 2'b00, 5'd0, 5'd0, 64'd0));
    #1 rst_n = 1'b1;

    load(0, 64'd1);
    load(1, 64'd5);
    load(2, 64'd3);

    // st len tmo cs data | busy pass fail cause mcnt fidx fdata
    vecs.push_back(mk_vec(1, 2, 100, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0));
    vecs.push_back(mk_vec(0, 0, 0,   1, 1, 1, 0, 0, 2'b00, 1, 0, 0));
    vecs.push_back(mk_vec(0, 0, 0,   0, 0, 1, 0, 0, 2'b00, 1, 0, 0));
    vecs.push_back(mk_vec(0, 0, 0,   1, 5, 0, 1, 0, 2'b00, 2, 0, 0));
    vecs.push_back(mk_vec(0, 0, 0,   0, 0, 0, 1, 0, 2'b00, 2, 0, 0));
    vecs.push_back(mk_vec(0, 0, 0,   1, 9, 0, 0, 1, 2'b11, 2, 2, 9));
    vecs.push_back(mk_vec(0, 0, 0,   0, 0, 0, 0, 1, 2'b11, 2, 2, 9));
    vecs.push_back(mk_vec(1, 2, 100, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0));
    vecs.push_back(mk_vec(0, 0, 0,   1, 1, 1, 0, 0, 2'b00, 1, 0, 0));
    vecs.push_back(mk_vec(0, 0, 0,   0, 0, 1, 0, 0, 2'b00, 1, 0, 0));
    vecs.push_back(mk_vec(0, 0, 0,   1, 7, 0, 0, 1, 2'b01, 1, 1, 7));
    vecs.push_back(mk_vec(0, 0, 0,   1, 7, 0, 0, 1, 2'b01, 1, 1, 7));
    vecs.push_back(mk_vec(0, 0, 0,   0, 0, 0, 0, 1, 2'b01, 1, 1, 7));
    vecs.push_back(mk_vec(0, 0, 0,   1, 1, 0, 0, 1, 2'b01, 1, 1, 7));
    vecs.push_back(mk_vec(0, 0, 0,   0, 0, 0, 0, 1, 2'b01, 1, 1, 7));
    vecs.push_back(mk_vec(1, 0, 0,   0, 0, 0, 1, 0, 2'b00, 0, 0, 0));

    foreach (vecs[i]) begin
      start = vecs[i].st; len = vecs[i].len; tmo = vecs[i].tmo;
      cs = vecs[i].cs; data = vecs[i].d;
      sb_q.push_back(mk_exp($sformatf("vec%0d", i), vecs[i].busy, vecs[i].pass, vecs[i].fail,
                            vecs[i].cause, vecs[i].mcnt, vecs[i].fidx, vecs[i].fdata));
      tick();
    end
    start = 1'b0; cs = 1'b0;

    // Held chip select is one event; timeout fires 10 edges after it
    arm("to_arm", 5'd2, 24'd10);
    cs = 1'b1; data = 64'd1;
    expect_now("to_ev", 1, 0, 0, 2'b00, 5'd1, 5'd0, 64'd0);
    tick();
    for (int k = 1; k <= 10; k++) begin
      cs = (k <= 4);
      if (k < 10) expect_now($sformatf("to_wait%0d", k), 1, 0, 0, 2'b00, 5'd1, 5'd0, 64'd0);
      else        expect_now("to_fire", 0, 0, 1, 2'b10, 5'd1, 5'd1, 64'd0);
      tick();
    end

    // Table writes and start are ignored while running
    arm("ro_arm", 5'd2, 24'd0);
    we = 1'b1; waddr = 4'd0; wdata = 64'hDEAD;
    expect_now("ro_we0", 1, 0, 0, 2'b00, 5'd0, 5'd0, 64'd0);
    tick();
    waddr = 4'd1; wdata = 64'hBEEF; start = 1'b1; len = 5'd0;
    expect_now("ro_we1", 1, 0, 0, 2'b00, 5'd0, 5'd0, 64'd0);
    tick();
    we = 1'b0; start = 1'b0;
    cs = 1'b1; data = 64'd1;
    expect_now("ro_m0", 1, 0, 0, 2'b00, 5'd1, 5'd0, 64'd0);
    tick();
    cs = 1'b0;
    tick();
    cs = 1'b1; data = 64'd5;
    expect_now("ro_m1", 0, 1, 0, 2'b00, 5'd2, 5'd0, 64'd0);
    tick();
    cs = 1'b0;
    tick();

    // Full depth with timeout disabled and a long idle gap mid-sequence
    for (int i = 0; i < DEPTH; i++) load(i, 64'(i));
    arm("fd_arm", 5'd16, 24'd0);
    for (int i = 0; i < DEPTH; i++) begin
      cs = 1'b1; data = 64'(i);
      if (i == DEPTH - 1) expect_now("fd_last", 0, 1, 0, 2'b00, 5'd16, 5'd0, 64'd0);
      else expect_now($sformatf("fd%0d", i), 1, 0, 0, 2'b00, 5'(i + 1), 5'd0, 64'd0);
      tick();
      cs = 1'b0;
      tick();
      if (i == 7) begin
        repeat (1000) @(posedge clk);
        #1;
        compare_out(mk_exp("fd_gap", 1, 0, 0, 2'b00, 5'd8, 5'd0, 64'd0));
      end
    end

    // Async reset in the middle of a run
    arm("rs_arm", 5'd2, 24'd100);
    cs = 1'b1; data = 64'd0;
    expect_now("rs_m0", 1, 0, 0, 2'b00, 5'd1, 5'd0, 64'd0);
    tick();
    cs = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    compare_out(mk_exp("rs_async", 0, 0, 0, 2'b00, 5'd0, 5'd0, 64'd0));
    #2 rst_n = 1'b1;
    expect_now("rs_idle", 0, 0, 0, 2'b00, 5'd0, 5'd0, 64'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
